// File: rtl/instruction_sequencer.sv
// Host byte-stream parser for the GPU draw executor: assembles opcode plus 0-3 argument
// bytes into a 32-bit instruction, issues it, then waits for completion or timeout.
module instruction_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic [31:0]      o_instruction,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  input  logic             i_cmd_done,
  output logic             o_busy,
  output logic             o_err_illegal,
  input  logic             i_err_clr,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cmd_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StOp, StArg, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [1:0]        arg_idx_q, arg_idx_d;
  logic [1:0]        args_left_q, args_left_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic       byte_ready;
  logic       xfer;
  logic       op_legal;
  logic [1:0] op_nargs;

  assign byte_ready = (state_q == StOp) || (state_q == StArg);
  assign xfer       = i_byte_valid && byte_ready;

  always_comb begin
    op_legal = 1'b1;
    op_nargs = 2'd0;
    case (i_byte)
      8'h00:   op_nargs = 2'd0;
      8'h01:   op_nargs = 2'd1;
      8'h02:   op_nargs = 2'd2;
      8'h03:   op_nargs = 2'd1;
      8'h04:   op_nargs = 2'd2;
      8'h05:   op_nargs = 2'd3;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    arg_idx_d   = arg_idx_q;
    args_left_d = args_left_q;
    tmo_cnt_d   = tmo_cnt_q;
    // A set in the same cycle as a clear must win, so clear first.
    err_d       = err_q & ~i_err_clr;
    timeout_d   = 1'b0;
    count_d     = count_q;

    unique case (state_q)
      StOp: begin
        if (xfer) begin
          if (!op_legal) begin
            err_d = 1'b1;
          end else if (op_nargs == 2'd0) begin
            count_d = count_q + CNT_W'(1);
          end else begin
            instr_d     = {24'h000000, i_byte};
            arg_idx_d   = 2'd0;
            args_left_d = op_nargs;
            state_d     = StArg;
          end
        end
      end
      StArg: begin
        if (xfer) begin
          case (arg_idx_q)
            2'd0:    instr_d[15:8]  = i_byte;
            2'd1:    instr_d[23:16] = i_byte;
            default: instr_d[31:24] = i_byte;
          endcase
          arg_idx_d   = arg_idx_q + 2'd1;
          args_left_d = args_left_q - 2'd1;
          if (args_left_q == 2'd1) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (i_cmd_ready) begin
          tmo_cnt_d = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (i_cmd_done) begin
          count_d = count_q + CNT_W'(1);
          state_d = StOp;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = StOp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      default: state_d = StOp;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StOp;
      instr_q     <= '0;
      arg_idx_q   <= '0;
      args_left_q <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      arg_idx_q   <= arg_idx_d;
      args_left_q <= args_left_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the first reset edge.
  assign o_byte_ready  = byte_ready && !i_reset;
  assign o_cmd_valid   = (state_q == StIssue) && !i_reset;
  assign o_instruction = o_cmd_valid ? instr_q : 32'h0;
  assign o_busy        = ((state_q == StIssue) || (state_q == StWait)) && !i_reset;
  assign o_err_illegal = err_q && !i_reset;
  assign o_timeout     = timeout_q && !i_reset;
  assign o_cmd_count   = i_reset ? '0 : count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_instruction_sequencer;

  localparam int unsigned T  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [31:0]   instr;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic          done = 1'b0;
  logic          busy;
  logic          err;
  logic          err_clr = 1'b0;
  logic          timeout;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  instruction_sequencer #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (CW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_byte       (data),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_instruction(instr),
    .o_cmd_valid  (cmd_valid),
    .i_cmd_ready  (cmd_ready),
    .i_cmd_done   (done),
    .o_busy       (busy),
    .o_err_illegal(err),
    .i_err_clr    (err_clr),
    .o_timeout    (timeout),
    .o_cmd_count  (count)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: bytes of the instruction being collected, whether it is
  // on offer or has been accepted, and when it was accepted.
  logic [7:0]    m_bytes[$];
  int            m_need = 0;
  bit            m_offered = 1'b0;
  bit            m_waiting = 1'b0;
  bit            m_err = 1'b0;
  bit            m_timeout = 1'b0;
  logic [CW-1:0] m_count = '0;
  int            m_cyc = 0;
  int            m_accept_cyc = 0;

  function automatic int nargs(input logic [7:0] op);
    case (op)
      8'h00: return 0;
      8'h01: return 1;
      8'h02: return 2;
      8'h03: return 1;
      8'h04: return 2;
      8'h05: return 3;
      default: return -1;
    endcase
  endfunction

  function logic [31:0] pack_instr();
    logic [31:0] r;
    r = 32'h0;
    foreach (m_bytes[i]) r = r | (32'(m_bytes[i]) << (8 * i));
    return r;
  endfunction

  always @(posedge clk) begin
    int n;
    m_cyc = m_cyc + 1;
    if (rst) begin
      m_bytes.delete();
      m_offered = 1'b0;
      m_waiting = 1'b0;
      m_err     = 1'b0;
      m_timeout = 1'b0;
      m_count   = '0;
    end else begin
      m_timeout = 1'b0;
      if (err_clr) m_err = 1'b0;
      if (m_waiting) begin
        if (done) begin
          m_count   = m_count + 1'b1;
          m_waiting = 1'b0;
        end else if (m_cyc - m_accept_cyc == T) begin
          m_timeout = 1'b1;
          m_waiting = 1'b0;
        end
      end else if (m_offered) begin
        if (cmd_ready) begin
          m_offered    = 1'b0;
          m_waiting    = 1'b1;
          m_accept_cyc = m_cyc;
          m_bytes.delete();
        end
      end else if (byte_valid) begin
        if (m_bytes.size() == 0) begin
          n = nargs(data);
          if (n < 0) m_err = 1'b1;
          else if (n == 0) m_count = m_count + 1'b1;
          else begin
            m_bytes.push_back(data);
            m_need = n;
          end
        end else begin
          m_bytes.push_back(data);
          if (m_bytes.size() == m_need + 1) m_offered = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_ready", 32'(byte_ready), 32'(!rst && !m_offered && !m_waiting));
      check("cmp_valid", 32'(cmd_valid), 32'(!rst && m_offered));
      check("cmp_instr", instr, (!rst && m_offered) ? pack_instr() : 32'h0);
      check("cmp_busy", 32'(busy), 32'(!rst && (m_offered || m_waiting)));
      check("cmp_err", 32'(err), 32'(!rst && m_err));
      check("cmp_timeout", 32'(timeout), 32'(!rst && m_timeout));
      check("cmp_count", 32'(count), rst ? 32'h0 : 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_valid = 1'b1;
    data = b;
    #1;
    while (!byte_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!byte_ready) begin
      tests++;
      fails++;
      $display("FAIL send_wait: ready never rose for byte %02h, expected within 50 cycles", b);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  initial begin
    int k;

    // Reset
    tick();
    chk_en = 1'b1;
    check("rst_ready", 32'(byte_ready), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(byte_ready), 32'h1);

    // 02 10 20 with valid held high
    byte_valid = 1'b1; data = 8'h02; tick();
    data = 8'h10; tick();
    data = 8'h20; tick();
    byte_valid = 1'b0;
    check("t1_valid", 32'(cmd_valid), 32'h1);
    check("t1_instr", instr, 32'h00201002);
    check("t1_ready_issue", 32'(byte_ready), 32'h0);
    accept();
    check("t1_wait_valid", 32'(cmd_valid), 32'h0);
    check("t1_busy", 32'(busy), 32'h1);
    done = 1'b1; tick(); done = 1'b0;
    check("t1_count", 32'(count), 32'h1);
    check("t1_ready_back", 32'(byte_ready), 32'h1);

    // FILL_RECT with executor stalling
    send(8'h05); send(8'hAA); send(8'hBB); send(8'hCC);
    for (int i = 0; i < 5; i++) begin
      check("t2_stable", instr, 32'hCCBBAA05);
      tick();
    end
    accept();
    tick(); tick();
    done = 1'b1; tick(); done = 1'b0;
    check("t2_count", 32'(count), 32'h2);
    check("t2_ready_back", 32'(byte_ready), 32'h1);

    // Illegal opcode, NOP, clear, set-beats-clear
    send(8'h7F);
    check("t3_err", 32'(err), 32'h1);
    send(8'h00);
    check("t3_err_sticky", 32'(err), 32'h1);
    check("t3_count", 32'(count), 32'h3);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_err_clr", 32'(err), 32'h0);
    err_clr = 1'b1; send(8'h99); err_clr = 1'b0;
    check("t3_set_wins", 32'(err), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Timeout
    send(8'h01); send(8'h33);
    accept();
    k = 0;
    while (!timeout && k < 20) begin
      tick();
      k++;
    end
    check("t4_tmo_latency", 32'(k), 32'd8);
    check("t4_count", 32'(count), 32'h3);
    tick();
    check("t4_tmo_pulse", 32'(timeout), 32'h0);
    send(8'h00);
    check("t4_next_op", 32'(count), 32'h4);

    // Done on the terminal wait cycle wins over timeout
    send(8'h01); send(8'h44);
    accept();
    repeat (7) tick();
    done = 1'b1; tick(); done = 1'b0;
    check("t5_no_tmo", 32'(timeout), 32'h0);
    check("t5_count", 32'(count), 32'h5);

    // Reset mid-argument
    send(8'h05); send(8'h11);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", 32'(byte_ready), 32'h0);
    check("t6_rst_count", 32'(count), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    send(8'h03); send(8'h41);
    check("t6_instr", instr, 32'h00004103);
    accept();
    done = 1'b1; tick(); done = 1'b0;

    // Counter wrap
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (15) send(8'h00);
    check("t7_count15", 32'(count), 32'hF);
    repeat (2) send(8'h00);
    check("t7_wrap", 32'(count), 32'h1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      byte_valid = $urandom_range(0, 1) == 1;
      data       = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      cmd_ready  = $urandom_range(0, 3) == 0;
      done       = $urandom_range(0, 11) == 0;
      err_clr    = $urandom_range(0, 15) == 0;
      tick();
    end
    rst = 1'b0; byte_valid = 1'b0; cmd_ready = 1'b0; done = 1'b0; err_clr = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Sits between the host byte link and the GPU draw executor.
- Parses the incoming byte stream into complete instructions: one opcode byte, then 0-3 argument bytes whose count depends on the opcode.
- Presents each complete 32-bit instruction to the executor with a valid/ready handshake, then waits for a completion pulse or a timeout before it accepts the next opcode.
- Rejects illegal opcodes, and keeps status and a count of completed instructions.

Parameters:
TIMEOUT_CYCLES, 1024, maximum number of cycles to wait in WAIT for i_cmd_done; must be ≥2.
CNT_W, 16, width of o_cmd_count.

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_byte  in  8  host byte.
i_byte_valid  in  1  i_byte is valid.
o_byte_ready  out  1  sequencer can accept a byte this cycle.
o_instruction  out  32  {arg2, arg1, arg0, opcode}; zero whenever o_cmd_valid=0.
o_cmd_valid  out  1  instruction is offered to the executor.
i_cmd_ready  in  1  executor accepts the instruction.
i_cmd_done  in  1  one-cycle pulse when the executor finishes.
o_busy  out  1  high in ISSUE or WAIT.
o_err_illegal  out  1  sticky illegal-opcode flag.
i_err_clr  in  1  clears o_err_illegal.
o_timeout  out  1  one-cycle pulse when the WAIT timeout expires.
o_cmd_count  out  CNT_W  completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Byte transfer occurs on a cycle where i_byte_valid && o_byte_ready.
- Opcode table (argument count):
  - 0x00 NOP (0)
  - 0x01 CLEAR (1)
  - 0x02 SET_CURSOR (2)
  - 0x03 PUT_CHAR (1)
  - 0x04 SET_COLOR (2)
  - 0x05 FILL_RECT (3)
  - all other values are illegal.
- States: OP, ARG, ISSUE, WAIT.
- OP (reset state): o_byte_ready=1. On a transfer:
  - NOP: o_cmd_count+1 on the next edge, remain in OP, no issue.
  - Illegal: o_err_illegal<=1, remain in OP, count unchanged.
  - Legal with N>0: latch the opcode, clear the argument register to 0, set the remaining-argument counter to N, go to ARG.
- ARG: o_byte_ready=1. Each transfer writes argument k (k=0..N-1, in arrival order) into o_instruction bits [8k+15:8k+8]; unused argument bytes stay 0. After the Nth argument, go to ISSUE on the next edge.
- ISSUE: o_byte_ready=0 and o_cmd_valid=1. o_instruction is held stable until i_cmd_ready=1. On the accepting edge, clear the timeout counter and go to WAIT. There is no timeout in ISSUE.
- WAIT: o_byte_ready=0 and o_cmd_valid=0.
  - i_cmd_done=1: o_cmd_count+1, go to OP.
  - Otherwise the timeout counter increments; when it reaches TIMEOUT_CYCLES-1 without done, pulse o_timeout for one cycle, go to OP, and leave the count unchanged.
  - If done and the terminal count occur in the same cycle, done wins: no timeout, count increments.
  - i_cmd_done is ignored in OP, ARG and ISSUE.
- Latency:
  - The last argument transfers at edge t; o_cmd_valid is high in the cycle after edge t.
  - Done is sampled at edge d; the sequencer is in OP after edge d, and o_byte_ready=1 in the following cycle.
- o_err_illegal:
  - Set by an illegal opcode, cleared by i_err_clr.
  - A simultaneous set and clear leaves it set.
  - It does not block parsing.
- o_busy = (state==ISSUE || state==WAIT).
- Reset (any state, including mid-instruction):
  - State goes to OP and any partial instruction is discarded.
  - o_cmd_valid=0, o_instruction=0, o_err_illegal=0, o_timeout=0, o_cmd_count=0, o_busy=0.
  - o_byte_ready=0 during the reset cycle and 1 on the first cycle after reset.
- Counter wrap: o_cmd_count goes from 2^CNT_W-1 to 0.
- Back-to-back operation: a new opcode can transfer on the first cycle the sequencer is back in OP.

Test Plan:
- Reset, then bytes 0x02, 0x10, 0x20 with valid held high -> o_cmd_valid asserted the cycle after 0x20 transfers with o_instruction=0x00201002; o_byte_ready=0 while in ISSUE.
- 0x05,0xAA,0xBB,0xCC with i_cmd_ready held low for 5 cycles, then high, then i_cmd_done 3 cycles later -> o_instruction=0xCCBBAA05 stable all 5 cycles; o_cmd_count 0->1; o_byte_ready=1 again in the cycle after the done edge.
- Opcode 0x7F, then 0x00 -> o_err_illegal=1 and stays 1, count=1 (from the NOP), no o_cmd_valid; i_err_clr -> o_err_illegal=0.
- 0x01,0x33 accepted, executor never sends done, TIMEOUT_CYCLES=8 -> o_timeout pulses once, 8 cycles after the accepting edge; count unchanged; next opcode accepted.
- i_reset asserted after 0x05,0x11 (mid-ARG), then 0x03,0x41 -> o_instruction=0x00004103 with no stale 0x11; all outputs 0 during the reset cycle.
- CNT_W=4 with 17 NOP bytes -> o_cmd_count wraps 15->0 and reads 1.
